// File: rtl/nic_ctrl.sv
// nic_ctrl: CPU-facing network interface controller with one-entry
// injection (output) and ejection (input) buffers.
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - asynchronous, active-high reset
//   nicAddr    - CPU register select (00 in-buf, 01 in-status,
//                10 out-buf, 11 out-status)
//   nicDataIn  - CPU write data
//   nicDataOut - CPU read data, registered, held between reads
//   nicEn      - CPU access strobe
//   nicWrEn    - 1 = write, 0 = read (only meaningful with nicEn)
//   net_so     - injection valid to router (out buffer full)
//   net_ro     - router ready to accept injection
//   net_do     - injection packet (always the out buffer)
//   net_si     - ejection valid from router
//   net_ri     - NIC ready for ejection (in buffer empty, not in reset)
//   net_di     - ejection packet
module nic_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [0:1]  nicAddr,
    input  logic [0:63] nicDataIn,
    output logic [0:63] nicDataOut,
    input  logic        nicEn,
    input  logic        nicWrEn,
    output logic        net_so,
    input  logic        net_ro,
    output logic [0:63] net_do,
    input  logic        net_si,
    output logic        net_ri,
    input  logic [0:63] net_di
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} chanState_t;

    chanState_t  inState;
    chanState_t  outState;
    logic [0:63] inBuf;
    logic [0:63] outBuf;

    logic inFull;
    logic outFull;
    logic cpuRd;
    logic cpuWr;

    assign inFull  = (inState == FULL);
    assign outFull = (outState == FULL);
    assign cpuRd   = nicEn & ~nicWrEn;
    assign cpuWr   = nicEn & nicWrEn;

    // Ready is also gated by reset so the router never sees a ready
    // window while the block is being cleared.
    assign net_ri = ~inFull & ~reset;
    assign net_so = outFull;
    assign net_do = outBuf;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inState    <= EMPTY;
            outState   <= EMPTY;
            inBuf      <= '0;
            outBuf     <= '0;
            nicDataOut <= '0;
        end else begin
            // Ejection channel: fill from the router, drained by a CPU read
            // of the in-buffer. Being in FULL means ready was low, so a
            // packet can never land on the same edge as the draining read.
            case (inState)
                EMPTY: begin
                    if (net_si) begin
                        inBuf   <= net_di;
                        inState <= FULL;
                    end
                end
                FULL: begin
                    if (cpuRd && nicAddr == 2'b00)
                        inState <= EMPTY;
                end
                default: inState <= EMPTY;
            endcase

            // Injection channel: filled by a CPU write, drained by the
            // router. A write seen while FULL is dropped even if the same
            // edge drains, since status is the pre-edge value.
            case (outState)
                EMPTY: begin
                    if (cpuWr && nicAddr == 2'b10) begin
                        outBuf   <= nicDataIn;
                        outState <= FULL;
                    end
                end
                FULL: begin
                    if (net_ro)
                        outState <= EMPTY;
                end
                default: outState <= EMPTY;
            endcase

            // Registered read port; holds on non-read cycles.
            if (cpuRd) begin
                case (nicAddr)
                    2'b00:   nicDataOut <= inBuf;
                    2'b01:   nicDataOut <= {63'b0, inFull};
                    2'b10:   nicDataOut <= outBuf;
                    default: nicDataOut <= {63'b0, outFull};
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nic_ctrl.sv
module tb_nic_ctrl;

    logic        clk;
    logic        reset;
    logic [0:1]  nicAddr;
    logic [0:63] nicDataIn;
    logic [0:63] nicDataOut;
    logic        nicEn;
    logic        nicWrEn;
    logic        net_so;
    logic        net_ro;
    logic [0:63] net_do;
    logic        net_si;
    logic        net_ri;
    logic [0:63] net_di;

    int checks = 0;
    int errors = 0;

    nic_ctrl dut (
        .clk(clk), .reset(reset), .nicAddr(nicAddr), .nicDataIn(nicDataIn),
        .nicDataOut(nicDataOut), .nicEn(nicEn), .nicWrEn(nicWrEn),
        .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
        .net_si(net_si), .net_ri(net_ri), .net_di(net_di)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  addr;
        logic        en;
        logic        wr;
        logic [63:0] din;
        logic        ro;
        logic        si;
        logic [63:0] di;
        logic [63:0] expOut;
        logic        expSo;
        logic        expRi;
        logic [63:0] expDo;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs[NV];

    localparam logic [63:0] DB = 64'hDEADBEEF_00000001;
    localparam logic [63:0] A5 = 64'hA5A5_0000_0000_5A5A;

    function automatic vec_t mk(logic [1:0] addr, logic en, logic wr, logic [63:0] din,
                                logic ro, logic si, logic [63:0] di,
                                logic [63:0] expOut, logic expSo, logic expRi,
                                logic [63:0] expDo);
        vec_t v;
        v.addr = addr; v.en = en; v.wr = wr; v.din = din; v.ro = ro;
        v.si = si; v.di = di; v.expOut = expOut; v.expSo = expSo;
        v.expRi = expRi; v.expDo = expDo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] addr, input logic en, input logic wr,
                         input logic [63:0] din, input logic ro, input logic si,
                         input logic [63:0] di);
        nicAddr = addr; nicEn = en; nicWrEn = wr; nicDataIn = din;
        net_ro = ro; net_si = si; net_di = di;
    endtask

    initial begin
        // addr en wr din ro si di | out so ri do  (expected after the edge)
        vecs[0]  = mk(2'b01, 1, 0, 0,        0, 0, 0,  64'h0, 0, 1, 64'h0);
        vecs[1]  = mk(2'b11, 1, 0, 0,        0, 0, 0,  64'h0, 0, 1, 64'h0);
        vecs[2]  = mk(2'b10, 1, 1, DB,       0, 0, 0,  64'h0, 1, 1, DB);
        vecs[3]  = mk(2'b11, 1, 0, 0,        0, 0, 0,  64'h1, 1, 1, DB);
        vecs[4]  = mk(2'b00, 0, 0, 0,        1, 0, 0,  64'h1, 0, 1, DB);
        vecs[5]  = mk(2'b11, 1, 0, 0,        0, 0, 0,  64'h0, 0, 1, DB);
        // write while full, same edge as drain: dropped
        vecs[6]  = mk(2'b10, 1, 1, 64'h1111, 0, 0, 0,  64'h0, 1, 1, 64'h1111);
        vecs[7]  = mk(2'b10, 1, 1, 64'h2,    1, 0, 0,  64'h0, 0, 1, 64'h1111);
        vecs[8]  = mk(2'b11, 1, 0, 0,        0, 0, 0,  64'h0, 0, 1, 64'h1111);
        // ejection, back-pressure, drain, next packet
        vecs[9]  = mk(2'b00, 0, 0, 0,        0, 1, A5, 64'h0, 0, 0, 64'h1111);
        vecs[10] = mk(2'b00, 0, 0, 0,        0, 1, 7,  64'h0, 0, 0, 64'h1111);
        vecs[11] = mk(2'b00, 1, 0, 0,        0, 1, 7,  A5,    0, 1, 64'h1111);
        vecs[12] = mk(2'b00, 0, 0, 0,        0, 1, 7,  A5,    0, 0, 64'h1111);
        vecs[13] = mk(2'b00, 1, 0, 0,        0, 0, 0,  64'h7, 0, 1, 64'h1111);
        // concurrent write + ejection
        vecs[14] = mk(2'b10, 1, 1, 64'hCAFE, 0, 1, 64'h33, 64'h7, 1, 0, 64'hCAFE);
        vecs[15] = mk(2'b01, 1, 0, 0,        0, 0, 0,  64'h1, 1, 0, 64'hCAFE);
        vecs[16] = mk(2'b11, 1, 0, 0,        0, 0, 0,  64'h1, 1, 0, 64'hCAFE);
        vecs[17] = mk(2'b00, 1, 0, 0,        1, 0, 0,  64'h33, 0, 1, 64'hCAFE);
        vecs[18] = mk(2'b00, 1, 0, 0,        0, 0, 0,  64'h33, 0, 1, 64'hCAFE);
        vecs[19] = mk(2'b01, 1, 0, 0,        0, 0, 0,  64'h0, 0, 1, 64'hCAFE);
        // writes to non-writable registers do nothing
        vecs[20] = mk(2'b00, 1, 1, 64'hFFFF, 0, 0, 0,  64'h0, 0, 1, 64'hCAFE);
        vecs[21] = mk(2'b11, 1, 1, 64'hFFFF, 0, 0, 0,  64'h0, 0, 1, 64'hCAFE);
        vecs[22] = mk(2'b00, 1, 0, 0,        0, 0, 0,  64'h33, 0, 1, 64'hCAFE);
        vecs[23] = mk(2'b11, 1, 0, 0,        0, 0, 0,  64'h0, 0, 1, 64'hCAFE);

        reset = 1'b1;
        drive(2'b00, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ri", {63'b0, net_ri}, 64'h0);
        chk("rst_so", {63'b0, net_so}, 64'h0);
        chk("rst_dout", nicDataOut, 64'h0);
        chk("rst_do", net_do, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rel_ri", {63'b0, net_ri}, 64'h1);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].addr, vecs[i].en, vecs[i].wr, vecs[i].din,
                  vecs[i].ro, vecs[i].si, vecs[i].di);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_dout", i), nicDataOut, vecs[i].expOut);
            chk($sformatf("v%0d_so", i), {63'b0, net_so}, {63'b0, vecs[i].expSo});
            chk($sformatf("v%0d_ri", i), {63'b0, net_ri}, {63'b0, vecs[i].expRi});
            chk($sformatf("v%0d_do", i), net_do, vecs[i].expDo);
        end

        // Reset with both channels full discards everything.
        drive(2'b10, 1, 1, 64'h4444, 0, 1, 64'h5555);
        @(posedge clk);
        #1;
        chk("full_so", {63'b0, net_so}, 64'h1);
        chk("full_ri", {63'b0, net_ri}, 64'h0);
        drive(2'b00, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #1;
        chk("mid_rst_so", {63'b0, net_so}, 64'h0);
        chk("mid_rst_ri", {63'b0, net_ri}, 64'h0);
        chk("mid_rst_do", net_do, 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_ri", {63'b0, net_ri}, 64'h1);
        chk("post_rst_so", {63'b0, net_so}, 64'h0);
        drive(2'b01, 1, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("post_rst_in_stat", nicDataOut, 64'h0);
        drive(2'b11, 1, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("post_rst_out_stat", nicDataOut, 64'h0);

        // Sustained ejection: router always valid, CPU always reading the
        // in-buffer -> a packet every other edge.
        drive(2'b00, 1, 0, 0, 0, 1, 64'h900);
        @(posedge clk); #1;
        chk("tp_fill1_ri", {63'b0, net_ri}, 64'h0);
        net_di = 64'h901;
        @(posedge clk); #1;
        chk("tp_drain1", nicDataOut, 64'h900);
        chk("tp_drain1_ri", {63'b0, net_ri}, 64'h1);
        @(posedge clk); #1;
        chk("tp_fill2_ri", {63'b0, net_ri}, 64'h0);
        drive(2'b00, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        // read at the fill2 edge returned stale-or-same 900; now read again
        drive(2'b00, 1, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("tp_data2", nicDataOut, 64'h901);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
